// File: rtl/axis_udp_gen_pkg.sv
// Shared types and default widths for the AXI-Stream UDP generator blocks.
package axis_udp_gen_pkg;

  localparam int unsigned SCHED_LEN_WIDTH = 16;
  localparam int unsigned SCHED_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/axis_udp_gen_sched.sv
// Frame scheduler: sequences frame length, inter-frame gap, frame count and
// start/stop, producing per-beat qualifiers that honour downstream tready.
module axis_udp_gen_sched
  import axis_udp_gen_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = SCHED_LEN_WIDTH,
  parameter int unsigned CNT_WIDTH = SCHED_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [LEN_WIDTH-1:0] frame_len_i,
  input  logic [LEN_WIDTH-1:0] gap_i,
  input  logic [CNT_WIDTH-1:0] frame_num_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic                 last_o,
  output logic                 sof_o,
  output logic                 gen_en_o,
  output logic [LEN_WIDTH-1:0] beat_idx_o,
  output logic [CNT_WIDTH-1:0] frame_idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   CNT_ONE = (CNT_WIDTH + 1)'(1);

  sched_state_t state_q, state_d;

  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] gap_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [LEN_WIDTH-1:0] beat_idx_q;
  logic [LEN_WIDTH-1:0] gap_cnt_q;
  logic [CNT_WIDTH-1:0] frame_idx_q;
  logic                 stop_pend_q;
  logic                 done_q;
  logic                 done_d;

  logic                 accept;
  logic                 last_beat;
  logic                 gap_end;
  logic                 num_hit;
  logic [CNT_WIDTH:0]   frame_next;

  // One extra bit keeps frame_idx+1 from wrapping before the num_q compare.
  always_comb begin
    frame_next = {1'b0, frame_idx_q} + CNT_ONE;
    accept     = (state_q == SEND) && ready_i;
    last_beat  = (beat_idx_q == (len_q - LEN_ONE));
    gap_end    = (gap_cnt_q == (gap_q - LEN_ONE));
    num_hit    = (num_q != '0) && (frame_next == {1'b0, num_q});
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept && last_beat) begin
          if (stop_pend_q || stop_i || num_hit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            state_d = SEND;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (stop_pend_q || stop_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_end) begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      len_q       <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      beat_idx_q  <= '0;
      gap_cnt_q   <= '0;
      frame_idx_q <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            len_q       <= (frame_len_i == '0) ? LEN_ONE : frame_len_i;
            gap_q       <= gap_i;
            num_q       <= frame_num_i;
            beat_idx_q  <= '0;
            gap_cnt_q   <= '0;
            frame_idx_q <= '0;
            stop_pend_q <= 1'b0;
          end
        end
        SEND: begin
          if (stop_i) begin
            stop_pend_q <= 1'b1;
          end
          if (accept) begin
            if (last_beat) begin
              beat_idx_q  <= '0;
              gap_cnt_q   <= '0;
              frame_idx_q <= frame_next[CNT_WIDTH-1:0];
            end else begin
              beat_idx_q <= beat_idx_q + LEN_ONE;
            end
          end
        end
        GAP: begin
          gap_cnt_q <= gap_cnt_q + LEN_ONE;
        end
        default: begin
          beat_idx_q <= '0;
        end
      endcase
    end
  end

  // Everything except gen_en_o comes from registers only, so tready has no
  // combinational path into the beat qualifiers.
  assign valid_o     = (state_q == SEND);
  assign sof_o       = (state_q == SEND) && (beat_idx_q == '0);
  assign last_o      = (state_q == SEND) && last_beat;
  assign gen_en_o    = valid_o && ready_i;
  assign beat_idx_o  = beat_idx_q;
  assign frame_idx_o = frame_idx_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_axis_udp_gen_sched.sv
// Self-checking bench for axis_udp_gen_sched: table-driven runs plus
// hand-written stop/reset sequences, with a beat scoreboard on the output.
module tb_axis_udp_gen_sched;

  localparam int unsigned LW = 16;
  localparam int unsigned CW = 32;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [LW-1:0] frame_len_i = '0;
  logic [LW-1:0] gap_i = '0;
  logic [CW-1:0] frame_num_i = '0;
  logic          ready_i = 1'b1;
  logic          valid_o, last_o, sof_o, gen_en_o, busy_o, done_o;
  logic [LW-1:0] beat_idx_o;
  logic [CW-1:0] frame_idx_o;

  axis_udp_gen_sched #(.LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .frame_len_i (frame_len_i),
    .gap_i       (gap_i),
    .frame_num_i (frame_num_i),
    .ready_i     (ready_i),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .sof_o       (sof_o),
    .gen_en_o    (gen_en_o),
    .beat_idx_o  (beat_idx_o),
    .frame_idx_o (frame_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [CW-1:0] frame;
    logic [LW-1:0] beat;
    logic          sof;
    logic          last;
  } beat_t;

  typedef struct {
    int unsigned len;
    int unsigned gap;
    int unsigned num;
    bit          tog;
    int unsigned exp_beats;
    int unsigned exp_busy;
    int unsigned exp_idle;
    int unsigned exp_frame;
  } vec_t;

  beat_t         exp_q[$];
  vec_t          vecs[6];
  int unsigned   tests = 0;
  int unsigned   fails = 0;
  int unsigned   busy_cnt, idle_cnt, gen_cnt, done_cnt;
  bit            stall_q = 1'b0;
  logic [LW+2:0] stall_snap;
  beat_t         mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pops on every accepted beat.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (busy_o) busy_cnt++;
      if (busy_o && !valid_o) idle_cnt++;
      if (gen_en_o) gen_cnt++;
      if (done_o) begin
        done_cnt++;
        check("done_busy_low", 64'(busy_o), 64'd0);
      end
      if (stall_q) check("stall_hold", 64'({valid_o, last_o, sof_o, beat_idx_o}), 64'(stall_snap));
      stall_q    = valid_o && !ready_i;
      stall_snap = {valid_o, last_o, sof_o, beat_idx_o};
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: frame %0d beat %0d accepted, none expected",
                   frame_idx_o, beat_idx_o);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat", 64'({frame_idx_o, beat_idx_o, sof_o, last_o}), 64'(mon_exp));
        end
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic clear_counters();
    busy_cnt = 0;
    idle_cnt = 0;
    gen_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic push_frames(input int unsigned len, input int unsigned frames,
                             input int unsigned beats_limit);
    int unsigned l;
    beat_t e;
    l = (len == 0) ? 1 : len;
    for (int unsigned f = 0; f < frames; f++) begin
      for (int unsigned b = 0; b < l && b < beats_limit; b++) begin
        e.frame = CW'(f);
        e.beat  = LW'(b);
        e.sof   = (b == 0);
        e.last  = (b == l - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input bit tog, input int unsigned budget);
    int unsigned c = 0;
    while (done_cnt == 0 && c < budget) begin
      step();
      if (tog) ready_i = ~ready_i;
      c++;
    end
    if (done_cnt == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done_o within %0d cycles", budget);
    end
    ready_i = 1'b1;
    repeat (3) step();
  endtask

  task automatic start_run(input int unsigned len, input int unsigned gap, input int unsigned num);
    frame_len_i = LW'(len);
    gap_i       = LW'(gap);
    frame_num_i = CW'(num);
    ready_i     = 1'b1;
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic do_run(input vec_t v);
    step();
    clear_counters();
    push_frames(v.len, v.num, 32'hFFFF_FFFF);
    start_run(v.len, v.gap, v.num);
    wait_done(v.tog, 400);
    check("run_beats", 64'(gen_cnt), 64'(v.exp_beats));
    check("run_busy_cycles", 64'(busy_cnt), 64'(v.exp_busy));
    check("run_gap_cycles", 64'(idle_cnt), 64'(v.exp_idle));
    check("run_done_pulses", 64'(done_cnt), 64'd1);
    check("run_frame_idx", 64'(frame_idx_o), 64'(v.exp_frame));
    check("run_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    //         len gap num tog beats busy idle frame
    vecs[0] = '{4, 2, 3, 1'b0, 12, 16, 4, 3};
    vecs[1] = '{3, 0, 2, 1'b0,  6,  6, 0, 2};
    vecs[2] = '{5, 0, 1, 1'b1,  5,  9, 0, 1};
    vecs[3] = '{0, 3, 2, 1'b0,  2,  5, 3, 2};
    vecs[4] = '{1, 1, 3, 1'b0,  3,  5, 2, 3};
    vecs[5] = '{2, 4, 2, 1'b1,  4, 11, 4, 2};

    clear_counters();
    repeat (2) step();
    check("reset_outputs", 64'({valid_o, last_o, sof_o, gen_en_o, busy_o, done_o, beat_idx_o, frame_idx_o}), 64'd0);
    rst_n_i = 1'b1;
    repeat (2) step();
    check("idle_outputs", 64'({valid_o, last_o, sof_o, busy_o, done_o, beat_idx_o, frame_idx_o}), 64'd0);

    foreach (vecs[i]) do_run(vecs[i]);

    // Continuous mode, stop on beat 0 of the fourth frame: frame completes, no GAP.
    step();
    clear_counters();
    push_frames(2, 4, 32'hFFFF_FFFF);
    start_run(2, 1, 0);
    c = 0;
    while (!(valid_o && frame_idx_o == 3 && beat_idx_o == 0) && c < 100) begin
      step();
      c++;
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    wait_done(1'b0, 100);
    check("stop_send_beats", 64'(gen_cnt), 64'd8);
    check("stop_send_gap_cycles", 64'(idle_cnt), 64'd3);
    check("stop_send_done_pulses", 64'(done_cnt), 64'd1);
    check("stop_send_frame_idx", 64'(frame_idx_o), 64'd4);
    check("stop_send_queue_empty", 64'(exp_q.size()), 64'd0);

    // Start while busy is ignored; stop during GAP ends the run on the next edge.
    step();
    clear_counters();
    push_frames(2, 1, 32'hFFFF_FFFF);
    start_run(2, 3, 0);
    frame_len_i = LW'(7);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    check("in_gap", 64'({busy_o, valid_o}), 64'b10);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    check("gap_stop_state", 64'({busy_o, done_o, valid_o}), 64'b010);
    repeat (4) step();
    check("gap_stop_done_pulses", 64'(done_cnt), 64'd1);
    check("gap_stop_frame_idx", 64'(frame_idx_o), 64'd1);
    check("gap_stop_queue_empty", 64'(exp_q.size()), 64'd0);

    // start and stop together in IDLE: nothing happens.
    clear_counters();
    start_i = 1'b1;
    stop_i  = 1'b1;
    step();
    start_i = 1'b0;
    stop_i  = 1'b0;
    check("start_stop_idle", 64'({busy_o, valid_o}), 64'd0);
    repeat (3) step();
    check("start_stop_busy_cycles", 64'(busy_cnt), 64'd0);
    check("start_stop_done_pulses", 64'(done_cnt), 64'd0);

    // Reset during beat 2 of a 4-beat frame, then restart from scratch.
    step();
    clear_counters();
    push_frames(4, 1, 2);
    start_run(4, 0, 1);
    c = 0;
    while (beat_idx_o != 2 && c < 20) begin
      step();
      c++;
    end
    rst_n_i = 1'b0;
    #1;
    check("async_reset_outputs", 64'({valid_o, last_o, sof_o, gen_en_o, busy_o, done_o, beat_idx_o, frame_idx_o}), 64'd0);
    check("async_reset_queue_empty", 64'(exp_q.size()), 64'd0);
    #2;
    rst_n_i = 1'b1;
    do_run('{4, 0, 1, 1'b0, 4, 4, 0, 1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
